// File: rtl/reorder_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reorder_buffer : circular in-order retirement buffer with out-of-order   |
// |                  writeback, operand lookup and mispredict flush.         |
// | Optional feature macro: ROB_WB_BYPASS_EN (same-cycle writeback lookup).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module reorder_buffer #(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             alloc_valid,
  input  logic [4:0]       alloc_dest,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_index,

  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_index,
  input  logic [31:0]      wb_data,
  input  logic             wb_mispredict,

  input  logic [IDX_W-1:0] q1_index,
  output logic             q1_ready,
  output logic [31:0]      q1_data,
  input  logic [IDX_W-1:0] q2_index,
  output logic             q2_ready,
  output logic [31:0]      q2_data,

  output logic             commit_we,
  output logic [4:0]       commit_addr,
  output logic [31:0]      commit_data,
  output logic [IDX_W-1:0] commit_index,

  output logic             rollback,
  output logic [IDX_W:0]   count
);

  localparam int             DEPTH      = 2 ** IDX_W;
  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    DRAIN  = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [DEPTH-1:0] entry_busy;
  logic [DEPTH-1:0] entry_done;
  logic [DEPTH-1:0] entry_misp;
  logic [4:0]       entry_dest  [DEPTH];
  logic [31:0]      entry_value [DEPTH];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;

  logic commit_fire;
  logic flush_now;
  logic alloc_fire;
  logic wb_fire;

  // Retirement, flush detection and allocation handshake.
  assign commit_fire = (state == NORMAL) & entry_busy[head] & entry_done[head];
  assign flush_now   = commit_fire & entry_misp[head];
  assign alloc_ready = (count < FULL_COUNT) & (state == NORMAL) & ~flush_now;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign alloc_index = tail;
  assign wb_fire     = wb_valid & (state == NORMAL) & entry_busy[wb_index];

`ifdef ROB_WB_BYPASS_EN
  logic q1_hit;
  logic q2_hit;

  assign q1_hit   = wb_valid & entry_busy[q1_index] & (wb_index == q1_index);
  assign q2_hit   = wb_valid & entry_busy[q2_index] & (wb_index == q2_index);
  assign q1_ready = q1_hit | (entry_busy[q1_index] & entry_done[q1_index]);
  assign q2_ready = q2_hit | (entry_busy[q2_index] & entry_done[q2_index]);
  assign q1_data  = q1_hit ? wb_data : entry_value[q1_index];
  assign q2_data  = q2_hit ? wb_data : entry_value[q2_index];
`else
  assign q1_ready = entry_busy[q1_index] & entry_done[q1_index];
  assign q2_ready = entry_busy[q2_index] & entry_done[q2_index];
  assign q1_data  = entry_value[q1_index];
  assign q2_data  = entry_value[q2_index];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= NORMAL;
    end else begin
      state <= state_next;
    end
  end

  // DRAIN shows the mispredicting commit; FLUSH raises rollback one cycle later.
  always_comb begin
    state_next = state;
    rollback   = 1'b0;
    case (state)
      NORMAL: begin
        if (flush_now) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = FLUSH;
      end
      FLUSH: begin
        state_next = NORMAL;
        rollback   = 1'b1;
      end
      default: begin
        state_next = NORMAL;
      end
    endcase
  end

  // Commit clears win over a same-cycle writeback to the retiring entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_busy <= '0;
      entry_done <= '0;
      entry_misp <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_dest[i]  <= '0;
        entry_value[i] <= '0;
      end
    end else if (flush_now) begin
      entry_busy <= '0;
      entry_done <= '0;
      entry_misp <= '0;
    end else begin
      if (alloc_fire) begin
        entry_busy[tail] <= 1'b1;
        entry_done[tail] <= 1'b0;
        entry_misp[tail] <= 1'b0;
        entry_dest[tail] <= alloc_dest;
      end
      if (wb_fire) begin
        entry_done[wb_index]  <= 1'b1;
        entry_value[wb_index] <= wb_data;
        entry_misp[wb_index]  <= wb_mispredict;
      end
      if (commit_fire) begin
        entry_busy[head] <= 1'b0;
        entry_done[head] <= 1'b0;
        entry_misp[head] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_now) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire) begin
        tail <= tail + 1'b1;
      end
      if (commit_fire) begin
        head <= head + 1'b1;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_we    <= 1'b0;
      commit_addr  <= '0;
      commit_data  <= '0;
      commit_index <= '0;
    end else begin
      commit_we <= commit_fire;
      if (commit_fire) begin
        commit_addr  <= entry_dest[head];
        commit_data  <= entry_value[head];
        commit_index <= head;
      end
    end
  end

endmodule
`default_nettype wire
